// File: rtl/iir_coeff_bank_loader.sv
`default_nettype none
// ============================================================================
// Module   : iir_coeff_bank_loader
// Brief    : Shadow/active coefficient bank for the 4th-order IIR filter.
//            A commit swaps the shadow bank into the active bank on one edge.
//            Optional readback port enabled by `define IIR_COEFF_READBACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module iir_coeff_bank_loader #(
  parameter int                  W             = 18,
  parameter logic signed [W-1:0] DEFAULT_B1    = 18'sh10000,
  parameter logic [2:0]          DEFAULT_SCALE = 3'd0,
  parameter bit                  REQUIRE_FULL  = 1'b0
) (
  input  logic                lr_clk,
  input  logic                reset,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  input  logic [3:0]          wr_addr_i,
  input  logic signed [W-1:0] wr_data_i,
  input  logic                commit_i,
  output logic                swap_done_o,
  output logic                commit_err_o,
  output logic                addr_err_o,
  output logic [7:0]          swap_count_o,
  output logic signed [W-1:0] b1_o,
  output logic signed [W-1:0] b2_o,
  output logic signed [W-1:0] b3_o,
  output logic signed [W-1:0] b4_o,
  output logic signed [W-1:0] b5_o,
  output logic signed [W-1:0] a2_o,
  output logic signed [W-1:0] a3_o,
  output logic signed [W-1:0] a4_o,
  output logic signed [W-1:0] a5_o,
  output logic [2:0]          scale_o
`ifdef IIR_COEFF_READBACK_EN
  ,
  input  logic [3:0]          rd_addr_i,
  output logic signed [W-1:0] rd_data_o
`endif
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_LOAD = 2'd1;
  localparam logic [1:0] c_ST_SWAP = 2'd2;

  localparam logic [3:0] c_SCALE_ADDR = 4'd9;
  localparam logic [9:0] c_ALL_DIRTY  = 10'h3FF;

  // Slot 0 (b1) resets to DEFAULT_B1, slots 1..8 to zero.
  localparam logic [8:0][W-1:0] c_BANK_RST = {{(8*W){1'b0}}, DEFAULT_B1};

  logic [1:0]          state_q, state_d;
  logic [8:0][W-1:0]   shadow_q, shadow_d;
  logic [8:0][W-1:0]   active_q, active_d;
  logic [2:0]          shadow_scale_q, shadow_scale_d;
  logic [2:0]          active_scale_q, active_scale_d;
  logic [9:0]          dirty_q, dirty_d;
  logic [7:0]          swap_count_q, swap_count_d;
  logic                swap_done_q, swap_done_d;
  logic                commit_err_q, commit_err_d;
  logic                addr_err_q, addr_err_d;

  logic                w_wr_fire;
  logic                w_addr_ok;
  logic                w_commit_ok;

  assign wr_ready_o = !reset && (state_q != c_ST_SWAP);
  assign w_wr_fire  = wr_valid_i && wr_ready_o;
  assign w_addr_ok  = (wr_addr_i <= c_SCALE_ADDR);

  always_comb begin
    shadow_d       = shadow_q;
    shadow_scale_d = shadow_scale_q;
    dirty_d        = dirty_q;
    addr_err_d     = addr_err_q;
    active_d       = active_q;
    active_scale_d = active_scale_q;
    swap_count_d   = swap_count_q;
    state_d        = state_q;
    w_commit_ok    = 1'b0;

    if (w_wr_fire) begin
      if (!w_addr_ok) begin
        addr_err_d = 1'b1;
      end else begin
        dirty_d[wr_addr_i] = 1'b1;
        if (wr_addr_i == c_SCALE_ADDR) begin
          shadow_scale_d = wr_data_i[2:0];
        end else begin
          shadow_d[wr_addr_i] = wr_data_i;
        end
      end
    end

    // A write on the commit edge is already folded into shadow_d/dirty_d here,
    // so it both lands in the active bank and counts toward a full bank.
    w_commit_ok = commit_i && (state_q == c_ST_LOAD) &&
                  (!REQUIRE_FULL || (dirty_d == c_ALL_DIRTY));

    case (state_q)
      c_ST_IDLE: begin
        if (dirty_d != 10'd0) begin
          state_d = c_ST_LOAD;
        end
      end
      c_ST_LOAD: begin
        if (w_commit_ok) begin
          state_d        = c_ST_SWAP;
          active_d       = shadow_d;
          active_scale_d = shadow_scale_d;
          dirty_d        = 10'd0;
          swap_count_d   = swap_count_q + 8'd1;
        end
      end
      c_ST_SWAP: begin
        state_d = c_ST_IDLE;
      end
      default: begin
        state_d = c_ST_IDLE;
      end
    endcase

    swap_done_d  = w_commit_ok;
    commit_err_d = commit_i && !w_commit_ok;
  end

  always_ff @(posedge lr_clk) begin
    if (reset) begin
      state_q        <= c_ST_IDLE;
      shadow_q       <= c_BANK_RST;
      active_q       <= c_BANK_RST;
      shadow_scale_q <= DEFAULT_SCALE;
      active_scale_q <= DEFAULT_SCALE;
      dirty_q        <= 10'd0;
      swap_count_q   <= 8'd0;
      swap_done_q    <= 1'b0;
      commit_err_q   <= 1'b0;
      addr_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      shadow_scale_q <= shadow_scale_d;
      active_scale_q <= active_scale_d;
      dirty_q        <= dirty_d;
      swap_count_q   <= swap_count_d;
      swap_done_q    <= swap_done_d;
      commit_err_q   <= commit_err_d;
      addr_err_q     <= addr_err_d;
    end
  end

  assign swap_done_o  = swap_done_q;
  assign commit_err_o = commit_err_q;
  assign addr_err_o   = addr_err_q;
  assign swap_count_o = swap_count_q;

  assign b1_o    = active_q[0];
  assign b2_o    = active_q[1];
  assign b3_o    = active_q[2];
  assign b4_o    = active_q[3];
  assign b5_o    = active_q[4];
  assign a2_o    = active_q[5];
  assign a3_o    = active_q[6];
  assign a4_o    = active_q[7];
  assign a5_o    = active_q[8];
  assign scale_o = active_scale_q;

`ifdef IIR_COEFF_READBACK_EN
  logic [W-1:0] rd_data_q;
  logic [W-1:0] w_rd_data;

  always_comb begin
    w_rd_data = '0;
    if (rd_addr_i < c_SCALE_ADDR) begin
      w_rd_data = active_q[rd_addr_i];
    end else if (rd_addr_i == c_SCALE_ADDR) begin
      w_rd_data = {{(W-3){1'b0}}, active_scale_q};
    end
  end

  always_ff @(posedge lr_clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= w_rd_data;
    end
  end

  assign rd_data_o = rd_data_q;
`endif

endmodule
`default_nettype wire
